// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the pipelined CPU data memory: access-size codes,
// controller state encoding and the latency counter width.
package cpu_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSV  = 2'd3;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage: one 4-lane write port with lane enables and a
// combinational 4-byte read at a word-aligned index. Contents are never reset.
module mem_byte_array #(
   parameter int DEPTH_BYTES = 1024,
   parameter int IDX_W       = 8
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [3:0]       be_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [31:0]      wdata_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [31:0]      rdata_o
);

   logic [7:0] mem_q [DEPTH_BYTES];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int l = 0; l < 4; l++) begin
            if (be_i[l]) begin
               mem_q[{widx_i, 2'(l)}] <= wdata_i[8*l +: 8];
            end
         end
      end
   end

   assign rdata_o = {mem_q[{ridx_i, 2'd3}], mem_q[{ridx_i, 2'd2}],
                     mem_q[{ridx_i, 2'd1}], mem_q[{ridx_i, 2'd0}]};

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: byte/half/word little-endian accesses with
// fixed latency, ready/stall handshake, and alignment/range/size error checks.
module data_memory_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic              ready_o,
   output logic              err_o,
   output logic              stall_o
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       store_q, store_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              wr_q, wr_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [31:0]       data_q, data_d;

   logic              req;
   logic [ADDR_W:0]   end_addr;
   logic              nxt_err;
   logic [31:0]       rd_word;
   logic [31:0]       shifted;
   logic [31:0]       load_val;
   logic              mem_we;
   logic [3:0]        mem_be;

   assign req = MemRead_i | MemWrite_i;

   // Sequencing and operand latching.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = addr_i;
               store_d = data_i;
               size_d  = size_i;
               uns_d   = unsigned_i;
               wr_d    = MemWrite_i;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Error check and load result are evaluated on the operands that will be
   // held during DONE, so the registered outputs line up with ready_o.
   always_comb begin
      end_addr = {1'b0, addr_d} + (ADDR_W+1)'(size_bytes(size_d)) - (ADDR_W+1)'(1);
      nxt_err  = (size_d == SZ_RSV)
               | ((size_d == SZ_HALF) & addr_d[0])
               | ((size_d == SZ_WORD) & (addr_d[1:0] != 2'b00))
               | (end_addr >= (ADDR_W+1)'(DEPTH_BYTES));
      shifted  = rd_word >> {addr_d[1:0], 3'b000};
      case (size_d)
         SZ_BYTE: load_val = {{24{shifted[7] & ~uns_d}}, shifted[7:0]};
         SZ_HALF: load_val = {{16{shifted[15] & ~uns_d}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
      ready_d = (state_d == DONE);
      err_d   = ready_d & nxt_err;
      data_d  = (ready_d && !nxt_err && !wr_d) ? load_val : 32'h0;
   end

   always_comb begin
      mem_we = (state_q == DONE) & wr_q & ~err_q;
      case (size_q)
         SZ_BYTE: mem_be = 4'b0001 << addr_q[1:0];
         SZ_HALF: mem_be = 4'b0011 << addr_q[1:0];
         default: mem_be = 4'b1111;
      endcase
   end

   mem_byte_array #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .IDX_W       (IDX_W)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .be_i    (mem_be),
      .widx_i  (addr_q[IDX_W+1:2]),
      .wdata_i (store_q << {addr_q[1:0], 3'b000}),
      .ridx_i  (addr_d[IDX_W+1:2]),
      .rdata_o (rd_word)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         store_q <= '0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         wr_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign data_o  = data_q;
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign stall_o = ((state_q == IDLE) & req) | (state_q == WAIT);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance with LATENCY=2 and one with
// LATENCY=1, checked against a byte-array reference model.
module tb_data_memory_ctrl;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        rd     [2];
   logic        wr     [2];
   logic [1:0]  sz     [2];
   logic        un     [2];
   logic [31:0] ad     [2];
   logic [31:0] di     [2];
   logic [31:0] dq     [2];
   logic        rdy    [2];
   logic        er     [2];
   logic        st     [2];

   logic [7:0]  ref_mem [2][DEPTH];
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(2)) dut0 (
      .clk_i(clk), .rst_i(rst[0]), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
      .size_i(sz[0]), .unsigned_i(un[0]), .addr_i(ad[0]), .data_i(di[0]),
      .data_o(dq[0]), .ready_o(rdy[0]), .err_o(er[0]), .stall_o(st[0]));

   data_memory_ctrl #(.ADDR_W(32), .DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst[1]), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
      .size_i(sz[1]), .unsigned_i(un[1]), .addr_i(ad[1]), .data_i(di[1]),
      .data_o(dq[1]), .ready_o(rdy[1]), .err_o(er[1]), .stall_o(st[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
      longint nb;
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      if (s == 2'd3) return 1'b1;
      if (s == 2'd1 && a[0]) return 1'b1;
      if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
      return (longint'({32'h0, a}) + nb > DEPTH);
   endfunction

   function automatic logic [31:0] model_load(input int idx, input logic [1:0] s,
                                              input bit u, input logic [31:0] a);
      logic [31:0] v;
      case (s)
         2'd0: begin
            v = {24'h0, ref_mem[idx][a]};
            if (!u && v[7]) v[31:8] = 24'hFFFFFF;
         end
         2'd1: begin
            v = {16'h0, ref_mem[idx][a+1], ref_mem[idx][a]};
            if (!u && v[15]) v[31:16] = 16'hFFFF;
         end
         default: v = {ref_mem[idx][a+3], ref_mem[idx][a+2], ref_mem[idx][a+1], ref_mem[idx][a]};
      endcase
      return v;
   endfunction

   task automatic model_store(input int idx, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d);
      int nb;
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) ref_mem[idx][a+i] = d[8*i +: 8];
   endtask

   // One complete access: request, wait for ready, verify against the model.
   task automatic run(input int idx, input bit w, input logic [1:0] s, input bit u,
                      input logic [31:0] a, input logic [31:0] d, input string tag);
      bit          exp_e;
      logic [31:0] exp_d;
      logic [31:0] got_d;
      logic        got_e;
      logic        seen;
      int          lat;
      int          stalls;
      exp_e = model_err(s, a);
      exp_d = (w || exp_e) ? 32'h0 : model_load(idx, s, u, a);
      @(negedge clk);
      rd[idx] = ~w; wr[idx] = w; sz[idx] = s; un[idx] = u; ad[idx] = a; di[idx] = d;
      #1 stalls = st[idx] ? 1 : 0;
      @(posedge clk);
      #1 rd[idx] = 1'b0; wr[idx] = 1'b0;
      ad[idx] = $urandom; di[idx] = $urandom; sz[idx] = 2'($urandom_range(0, 3));
      lat = 1; seen = 1'b0; got_d = 32'h0; got_e = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         stalls += st[idx] ? 1 : 0;
         if (rdy[idx]) begin
            seen = 1'b1; got_d = dq[idx]; got_e = er[idx];
            break;
         end
         @(posedge clk);
         lat++;
      end
      check({tag, " ready"}, 32'(seen), 32'h1);
      check({tag, " err"}, 32'(got_e), 32'(exp_e));
      check({tag, " data"}, got_d, exp_d);
      check({tag, " latency"}, lat, (idx == 0) ? 2 : 1);
      check({tag, " stall_cycles"}, stalls, (idx == 0) ? 2 : 1);
      @(negedge clk);
      check({tag, " ready_pulse"}, 32'(rdy[idx]), 32'h0);
      if (w && !exp_e) model_store(idx, s, a, d);
   endtask

   // Word write of 0xDEADBEEF to 0x40 cut off by reset after the accept edge.
   task automatic abort_write(input int idx, input string tag);
      int pulses;
      @(negedge clk);
      wr[idx] = 1'b1; sz[idx] = 2'd2; ad[idx] = 32'h40; di[idx] = 32'hDEADBEEF;
      @(posedge clk);
      #1 wr[idx] = 1'b0;
      rst[idx] = 1'b1;
      #1;
      check({tag, " rst_ready"}, 32'(rdy[idx]), 32'h0);
      check({tag, " rst_err"}, 32'(er[idx]), 32'h0);
      check({tag, " rst_data"}, dq[idx], 32'h0);
      check({tag, " rst_stall"}, 32'(st[idx]), 32'h0);
      repeat (2) @(negedge clk);
      rst[idx] = 1'b0;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         pulses += rdy[idx] ? 1 : 0;
      end
      check({tag, " no_ready"}, pulses, 0);
      run(idx, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, {tag, " readback"});
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'd0;
         un[i] = 1'b0; ad[i] = 32'h0; di[i] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset%0d ready", i), 32'(rdy[i]), 32'h0);
         check($sformatf("reset%0d err", i), 32'(er[i]), 32'h0);
         check($sformatf("reset%0d data", i), dq[i], 32'h0);
         check($sformatf("reset%0d stall", i), 32'(st[i]), 32'h0);
      end
      rst[0] = 1'b0; rst[1] = 1'b0;

      run(0, 1, 2'd2, 0, 32'h10, 32'h89ABCDEF, "wr_word_10");
      run(0, 0, 2'd2, 0, 32'h10, 32'h0, "rd_word_10");
      run(0, 0, 2'd0, 0, 32'h13, 32'h0, "rd_byte_13_s");
      run(0, 0, 2'd0, 1, 32'h13, 32'h0, "rd_byte_13_u");
      run(0, 0, 2'd1, 0, 32'h10, 32'h0, "rd_half_10_s");
      run(0, 0, 2'd1, 1, 32'h10, 32'h0, "rd_half_10_u");
      run(0, 1, 2'd0, 0, 32'h11, 32'hFFFFFF55, "wr_byte_11");
      run(0, 0, 2'd2, 0, 32'h10, 32'h0, "rd_word_10_merged");
      check("merged_value", model_load(0, 2'd2, 0, 32'h10), 32'h89AB55EF);

      run(0, 1, 2'd2, 0, 32'h20, 32'h12345678, "wr_word_20");
      run(0, 0, 2'd2, 0, 32'h12, 32'h0, "rd_word_12_misaligned");
      run(0, 1, 2'd1, 0, 32'h21, 32'hAAAA5555, "wr_half_21_misaligned");
      run(0, 0, 2'd2, 0, 32'h20, 32'h0, "rd_word_20_unchanged");
      run(0, 0, 2'd3, 0, 32'h20, 32'h0, "rd_reserved_size");

      run(0, 1, 2'd2, 0, DEPTH - 4, 32'hCAFEF00D, "wr_word_top");
      run(0, 0, 2'd2, 0, DEPTH - 2, 32'h0, "rd_word_depth_m2");
      run(0, 0, 2'd0, 0, DEPTH, 32'h0, "rd_byte_depth");
      run(0, 0, 2'd2, 0, DEPTH - 4, 32'h0, "rd_word_depth_m4");
      run(0, 0, 2'd0, 0, 32'hFFFFFFFF, 32'h0, "rd_byte_addr_max");
      run(0, 1, 2'd2, 0, 32'hFFFFFFFC, 32'h11111111, "wr_word_addr_wrap");

      for (int i = 0; i < 16; i++) run(0, 1, 2'd2, 0, 32'h100 + 4 * i, $urandom, "prefill");
      run(0, 1, 2'd2, 0, DEPTH - 8, $urandom, "prefill_top");
      for (int i = 0; i < 50; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 4) == 0) ? 32'(DEPTH - 8 + $urandom_range(0, 15))
                                         : 32'(32'h100 + $urandom_range(0, 63));
         run(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $sformatf("rand%0d", i));
      end

      run(0, 1, 2'd2, 0, 32'h40, 32'h0, "clear_40");
      abort_write(0, "abort_wait");

      run(1, 1, 2'd2, 0, 32'h10, 32'h89ABCDEF, "l1_wr_word_10");
      run(1, 0, 2'd2, 0, 32'h10, 32'h0, "l1_rd_word_10");
      run(1, 0, 2'd0, 0, 32'h13, 32'h0, "l1_rd_byte_13_s");
      run(1, 1, 2'd1, 0, 32'h12, 32'h00007E01, "l1_wr_half_12");
      run(1, 0, 2'd2, 0, 32'h10, 32'h0, "l1_rd_word_10b");
      run(1, 0, 2'd2, 0, 32'h11, 32'h0, "l1_rd_misaligned");
      run(1, 1, 2'd2, 0, 32'h40, 32'h0, "l1_clear_40");
      abort_write(1, "l1_abort_done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
